// File: rtl/instr_prefetch_queue_pkg.sv
// Shared fetch/decode definitions: datapath width, the NOP encoding
// shown on an empty decode slot, and the prefetch slot record.
package instr_prefetch_queue_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } slot_t;

endpackage

// File: rtl/pf_slot_ring.sv
// DEPTH-entry ring of prefetch slots with separate allocate, fill and
// pop pointers plus an allocated-entry count.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush_i       drop every slot and rewind all pointers
//   alloc_i       reserve slot[alloc_ptr] for alloc_pc_i (unfilled)
//   fill_i        write fill_instr_i into slot[fill_ptr], mark filled
//   pop_i         release slot[rd_ptr]
//   head_o        slot at rd_ptr
//   cnt_o         allocated entries (reserved, filled or not)
module pf_slot_ring
    import instr_prefetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            alloc_i,
    input  logic [XLEN-1:0] alloc_pc_i,
    input  logic            fill_i,
    input  logic [XLEN-1:0] fill_instr_i,
    input  logic            pop_i,
    output slot_t           head_o,
    output logic [CW-1:0]   cnt_o
);

    slot_t         slot_q [DEPTH];
    slot_t         slot_d [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] al_q, al_d;
    logic [PW-1:0] fl_q, fl_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Allocate, fill and pop never address the same slot in one cycle:
    // the alloc slot is free, the fill slot is reserved but unfilled,
    // and the pop slot is filled.
    always_comb begin
        slot_d = slot_q;
        rd_d   = rd_q;
        al_d   = al_q;
        fl_d   = fl_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_d[i].filled = 1'b0;
            end
            rd_d  = '0;
            al_d  = '0;
            fl_d  = '0;
            cnt_d = '0;
        end else begin
            if (alloc_i) begin
                slot_d[al_q] = '{pc: alloc_pc_i, instr: NOP_INSTR, filled: 1'b0};
                al_d = al_q + PW'(1);
            end
            if (fill_i) begin
                slot_d[fl_q].instr  = fill_instr_i;
                slot_d[fl_q].filled = 1'b1;
                fl_d = fl_q + PW'(1);
            end
            if (pop_i) begin
                slot_d[rd_q].filled = 1'b0;
                rd_d = rd_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(alloc_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            rd_q  <= '0;
            al_q  <= '0;
            fl_q  <= '0;
            cnt_q <= '0;
        end else begin
            slot_q <= slot_d;
            rd_q   <= rd_d;
            al_q   <= al_d;
            fl_q   <= fl_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_o = slot_q[rd_q];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// In-order instruction prefetcher between a req/gnt+rvalid memory bus
// and Decode; redirects on taken branches from Execute.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   pcsrcE, pctargetE              redirect request and target
//   imem_req/addr/gnt              fetch request handshake
//   imem_rvalid/rdata              in-order fetch responses
//   validD/readyD                  decode handshake
//   instrD, pcD, pcincr4D          head instruction, its PC, PC+4
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pcsrcE,
    input  logic [XLEN-1:0] pctargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            validD,
    input  logic            readyD,
    output logic [XLEN-1:0] instrD,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pcincr4D
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   alloc_cnt;
    slot_t           head;
    logic            issue, rsp, fill, pop;

    // Issue is gated on the registered count; a same-cycle pop does
    // not free a slot for issue until the next cycle.
    assign imem_req  = !rst && !pcsrcE && (alloc_cnt < CW'(DEPTH));
    assign imem_addr = fetch_pc_q;
    assign issue     = imem_req && imem_gnt;

    // A response with nothing outstanding is a bus protocol error.
    assign rsp  = imem_rvalid && (inflight_q != '0);
    assign fill = rsp && (discard_q == '0) && !pcsrcE;

    assign validD = head.filled && !pcsrcE;
    assign pop    = validD && readyD;

    assign instrD   = validD ? head.instr : NOP_INSTR;
    assign pcD      = validD ? head.pc : '0;
    assign pcincr4D = validD ? head.pc + 32'd4 : '0;

    always_comb begin
        fetch_pc_d = issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
        inflight_d = inflight_q + CW'(issue) - CW'(rsp);
        discard_d  = discard_q - CW'(rsp && (discard_q != '0));
        if (pcsrcE) begin
            // Everything still outstanding after this cycle is stale;
            // a response landing now is dropped along with them.
            fetch_pc_d = pctargetE;
            inflight_d = inflight_q - CW'(rsp);
            discard_d  = inflight_q - CW'(rsp);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    pf_slot_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (pcsrcE),
        .alloc_i      (issue),
        .alloc_pc_i   (fetch_pc_q),
        .fill_i       (fill),
        .fill_instr_i (imem_rdata),
        .pop_i        (pop),
        .head_o       (head),
        .cnt_o        (alloc_cnt)
    );

    a_rvalid_outstanding: assert property (
        @(posedge clk) disable iff (rst) imem_rvalid |-> (inflight_q != '0)
    );

    a_counter_bounds: assert property (
        @(posedge clk) disable iff (rst)
        (discard_q <= inflight_q) && (inflight_q <= CW'(DEPTH))
    );

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with an in-order memory
// responder and a PC/instruction scoreboard on the decode port.
module tb_instr_prefetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, pcsrcE, readyD;
    logic [31:0] pctargetE;
    logic        imem_req, imem_gnt, imem_rvalid, validD;
    logic [31:0] imem_addr, imem_rdata, instrD, pcD, pcincr4D;

    logic        gnt_en, resp_en;
    logic [31:0] pend [$];
    logic [31:0] exp_q [$];
    logic [31:0] mdl_pc;
    int          n_cmp = 0, n_bad = 0, n_pop = 0, n_gnt = 0;
    int          p0;

    always #5 clk = ~clk;

    assign imem_gnt = gnt_en;

    instr_prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pcsrcE      (pcsrcE),
        .pctargetE   (pctargetE),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .validD      (validD),
        .readyD      (readyD),
        .instrD      (instrD),
        .pcD         (pcD),
        .pcincr4D    (pcincr4D)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0003;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Memory: one response per cycle, in order, one cycle after grant.
    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            if (imem_rvalid) void'(pend.pop_front());
            if (imem_req && imem_gnt) pend.push_back(imem_addr);
            if (resp_en && pend.size() > 0) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem_word(pend[0]);
            end else begin
                imem_rvalid <= 1'b0;
            end
        end
    end

    // Scoreboard: expected PCs pushed on grant, popped on decode accept.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mdl_pc = 32'h0;
            n_gnt  = 0;
        end else begin
            check("req", 32'(imem_req), 32'(!pcsrcE && exp_q.size() < 4));
            if (!validD) begin
                check("idle_instr", instrD, NOP);
                check("idle_pc", pcD, 32'h0);
                check("idle_pc4", pcincr4D, 32'h0);
            end
            if (pcsrcE) begin
                check("redir_valid", 32'(validD), 32'h0);
                exp_q.delete();
                mdl_pc = pctargetE;
            end else begin
                if (validD && readyD) begin
                    check("pop_expected", 32'(exp_q.size() != 0), 32'h1);
                    if (exp_q.size() != 0) begin
                        p0 = int'(exp_q.pop_front());
                        check("pcD", pcD, 32'(p0));
                        check("instrD", instrD, mem_word(32'(p0)));
                        check("pcincr4D", pcincr4D, 32'(p0) + 32'd4);
                    end
                    n_pop++;
                end
                if (imem_req && imem_gnt) begin
                    check("imem_addr", imem_addr, mdl_pc);
                    exp_q.push_back(mdl_pc);
                    mdl_pc = mdl_pc + 32'd4;
                    n_gnt++;
                end
            end
        end
    end

    initial begin
        int base;
        rst = 1'b1; pcsrcE = 1'b0; pctargetE = '0;
        gnt_en = 1'b0; resp_en = 1'b1; readyD = 1'b0;

        // 1: reset state
        step(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req", 32'(imem_req), 32'h1);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(validD), 32'h0);
        check("rst_instr", instrD, NOP);
        check("rst_pc", pcD, 32'h0);
        check("rst_pc4", pcincr4D, 32'h0);

        // 2: streaming at full rate
        step(1);
        gnt_en = 1'b1; readyD = 1'b1;
        base = n_pop;
        step(20);
        check("s2_pops", 32'(n_pop - base), 32'd18);

        // 3: backpressure fills the queue, then drains
        rst = 1'b1; step(1); rst = 1'b0;
        readyD = 1'b0; gnt_en = 1'b1; resp_en = 1'b1;
        step(8);
        check("s3_grants", 32'(n_gnt), 32'd4);
        @(negedge clk);
        check("s3_req_off", 32'(imem_req), 32'h0);
        check("s3_valid", 32'(validD), 32'h1);
        check("s3_pc_hold", pcD, 32'h0);
        step(3);
        @(negedge clk);
        check("s3_pc_stable", pcD, 32'h0);
        check("s3_instr_stable", instrD, mem_word(32'h0));
        step(1);
        readyD = 1'b1;
        step(12);
        check("s3_resumed", 32'(n_gnt > 4), 32'h1);

        // 4: redirect with three requests outstanding
        rst = 1'b1; step(1); rst = 1'b0;
        readyD = 1'b1; resp_en = 1'b0; gnt_en = 1'b1;
        step(3);
        pcsrcE = 1'b1; pctargetE = 32'h100; resp_en = 1'b1;
        step(1);
        pcsrcE = 1'b0;
        @(negedge clk);
        check("s4_addr", imem_addr, 32'h100);
        check("s4_req", 32'(imem_req), 32'h1);
        base = n_pop;
        step(14);
        check("s4_progress", 32'(n_pop > base), 32'h1);

        // 5: redirect coinciding with a response and a ready head
        rst = 1'b1; step(1); rst = 1'b0;
        readyD = 1'b0; gnt_en = 1'b1; resp_en = 1'b1;
        step(1);
        resp_en = 1'b0;
        step(2);
        gnt_en = 1'b0; resp_en = 1'b1;
        step(1);
        pcsrcE = 1'b1; pctargetE = 32'h200; readyD = 1'b1;
        base = n_pop;
        @(negedge clk);
        check("s5_rvalid_now", 32'(imem_rvalid), 32'h1);
        check("s5_valid", 32'(validD), 32'h0);
        step(1);
        pcsrcE = 1'b0; gnt_en = 1'b1;
        @(negedge clk);
        check("s5_no_pop", 32'(n_pop - base), 32'h0);
        check("s5_addr", imem_addr, 32'h200);
        step(13);
        check("s5_progress", 32'(n_pop > base), 32'h1);

        // 6: reset mid-stream, 2 buffered and 2 in flight
        rst = 1'b1; step(1); rst = 1'b0;
        readyD = 1'b0; gnt_en = 1'b1; resp_en = 1'b1;
        step(2);
        resp_en = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check("s6_valid", 32'(validD), 32'h0);
        check("s6_addr", imem_addr, 32'h0);
        check("s6_req", 32'(imem_req), 32'h1);
        check("s6_pc", pcD, 32'h0);
        step(1);
        resp_en = 1'b1; readyD = 1'b1;
        base = n_pop;
        step(10);
        check("s6_progress", 32'(n_pop > base), 32'h1);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
